hamming_codificador_tx: RTL

- Upstream stage for the Hamming (7,4) decoder/7-segment stage: turns the 4-bit switch value into the 7-bit codeword `palabra` that stage consumes.
- On each debounced press of the send button it captures the switches and encodes them.
- It can optionally flip one codeword bit (error injection) to exercise the downstream corrector.
- It presents the word with a valid/ready handshake and counts accepted words.

---
 rtl/hamming_codificador_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hamming_codificador_tx.sv
// Hamming (7,4) transmitter: debounced send button captures the switches, encodes them,
// optionally flips one codeword bit, and offers the word on a valid/ready handshake.
module hamming_codificador_tx #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] dato_i,
    input  logic       enviar_i,
    input  logic [2:0] inyectar_i,
    input  logic       listo_i,
    output logic [6:0] palabra_o,
    output logic       valido_o,
    output logic       ocupado_o,
    output logic [7:0] cuenta_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {REPOSO, CODIFICA, ESPERA} estado_t;

    estado_t estado_q, estado_d;

    logic [3:0]    dato_s1_q, dato_s1_d, dato_s2_q, dato_s2_d;
    logic [2:0]    iny_s1_q, iny_s1_d, iny_s2_q, iny_s2_d;
    logic          env_s1_q, env_s1_d, env_s2_q, env_s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nivel_q, nivel_d;
    logic          pulso_q, pulso_d;
    logic [3:0]    dato_cap_q, dato_cap_d;
    logic [2:0]    iny_cap_q, iny_cap_d;
    logic [6:0]    palabra_q, palabra_d;
    logic [7:0]    cuenta_q, cuenta_d;
    logic [6:0]    codigo;
    logic [6:0]    mascara;
    logic          acepta;

    always_ff @(posedge clk_i) begin
        if (rst_i) estado_q <= REPOSO;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            REPOSO:   if (pulso_q) estado_d = CODIFICA;
            CODIFICA: estado_d = ESPERA;
            ESPERA:   if (listo_i) estado_d = REPOSO;
            default:  estado_d = REPOSO;
        endcase
    end

    always_comb begin
        valido_o  = (estado_q == ESPERA);
        ocupado_o = (estado_q == CODIFICA) || (estado_q == ESPERA);
    end

    assign acepta = (estado_q == ESPERA) && listo_i;

    // Codeword positions 1..7 are palabra bits 0..6 = {p1, p2, d0, p3, d1, d2, d3}.
    always_comb begin
        codigo[0] = dato_cap_q[0] ^ dato_cap_q[1] ^ dato_cap_q[3];
        codigo[1] = dato_cap_q[0] ^ dato_cap_q[2] ^ dato_cap_q[3];
        codigo[2] = dato_cap_q[0];
        codigo[3] = dato_cap_q[1] ^ dato_cap_q[2] ^ dato_cap_q[3];
        codigo[4] = dato_cap_q[1];
        codigo[5] = dato_cap_q[2];
        codigo[6] = dato_cap_q[3];
        mascara   = (iny_cap_q != 3'd0) ? (7'd1 << (iny_cap_q - 3'd1)) : 7'd0;
    end

    always_comb begin
        dato_s1_d  = dato_i;
        dato_s2_d  = dato_s1_q;
        iny_s1_d   = inyectar_i;
        iny_s2_d   = iny_s1_q;
        env_s1_d   = enviar_i;
        env_s2_d   = env_s1_q;
        cnt_d      = cnt_q;
        nivel_d    = nivel_q;
        pulso_d    = 1'b0;
        dato_cap_d = dato_cap_q;
        iny_cap_d  = iny_cap_q;
        palabra_d  = palabra_q;
        cuenta_d   = cuenta_q;

        // Toggle on the edge where the counter would reach DEBOUNCE_CYCLES; pulse on rise only.
        if (env_s2_q == nivel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            nivel_d = ~nivel_q;
            pulso_d = ~nivel_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (estado_q == REPOSO && pulso_q) begin
            dato_cap_d = dato_s2_q;
            iny_cap_d  = iny_s2_q;
        end
        if (estado_q == CODIFICA) palabra_d = codigo ^ mascara;
        if (acepta)               cuenta_d  = cuenta_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dato_s1_q  <= '0;
            dato_s2_q  <= '0;
            iny_s1_q   <= '0;
            iny_s2_q   <= '0;
            env_s1_q   <= 1'b0;
            env_s2_q   <= 1'b0;
            cnt_q      <= '0;
            nivel_q    <= 1'b0;
            pulso_q    <= 1'b0;
            dato_cap_q <= '0;
            iny_cap_q  <= '0;
            palabra_q  <= '0;
            cuenta_q   <= '0;
        end else begin
            dato_s1_q  <= dato_s1_d;
            dato_s2_q  <= dato_s2_d;
            iny_s1_q   <= iny_s1_d;
            iny_s2_q   <= iny_s2_d;
            env_s1_q   <= env_s1_d;
            env_s2_q   <= env_s2_d;
            cnt_q      <= cnt_d;
            nivel_q    <= nivel_d;
            pulso_q    <= pulso_d;
            dato_cap_q <= dato_cap_d;
            iny_cap_q  <= iny_cap_d;
            palabra_q  <= palabra_d;
            cuenta_q   <= cuenta_d;
        end
    end

    assign palabra_o = palabra_q;
    assign cuenta_o  = cuenta_q;

endmodule
